// File: rtl/duck_ctl_if.sv
// duck_ctl_if: frame/spawn/hit requests into duck_ctl and the sprite-side position/status it returns
interface duck_ctl_if;
  logic new_frame, start, shot_hit;
  logic [9:0] duck_x, duck_y;
  logic duck_show, duck_hit, killed, escaped, busy;
  modport master (
    output new_frame, start, shot_hit,
    input  duck_x, duck_y, duck_show, duck_hit, killed, escaped, busy
  );
  modport slave (
    input  new_frame, start, shot_hit,
    output duck_x, duck_y, duck_show, duck_hit, killed, escaped, busy
  );
endinterface

// File: rtl/duck_ctl.sv
// duck_ctl: duck spawn / flight / hit / fall / escape motion controller, stepping once per video frame
module duck_ctl #(
  parameter int X_MAX       = 576,
  parameter int GROUND_Y    = 352,
  parameter int SPEED       = 2,
  parameter int FALL_SPEED  = 4,
  parameter int HIT_FREEZE  = 30,
  parameter int FLY_FRAMES  = 600,
  parameter int TURN_PERIOD = 64
) (
  input logic clk,
  input logic rst,
  duck_ctl_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FLY = 3'd1, S_HIT = 3'd2, S_FALL = 3'd3, S_ESC = 3'd4;
  localparam logic [9:0] XM = 10'(X_MAX), GY = 10'(GROUND_Y), SP = 10'(SPEED), FS = 10'(FALL_SPEED);
  localparam logic [9:0] HF = 10'(HIT_FREEZE), FF = 10'(FLY_FRAMES), TP = 10'(TURN_PERIOD);
  logic [2:0] r_state;
  logic [15:0] r_lfsr;
  logic [9:0] r_cnt, r_x, r_y;
  logic r_dx, r_dy;
  logic r_show, r_hit, r_killed, r_escaped, r_busy;
  logic w_turn, w_dx, w_dy, w_xlo, w_xhi, w_ylo, w_yhi;
  logic signed [10:0] w_nx, w_ny;
  logic [10:0] w_fy;
  // direction bits: 1 = moving toward smaller coordinates
  assign w_turn = r_cnt != '0 && r_cnt % TP == '0;
  assign w_dx = w_turn ? r_lfsr[0] : r_dx;
  assign w_dy = w_turn ? r_lfsr[1] : r_dy;
  assign w_nx = w_dx ? $signed({1'b0, r_x} - {1'b0, SP}) : $signed({1'b0, r_x} + {1'b0, SP});
  assign w_ny = w_dy ? $signed({1'b0, r_y} - {1'b0, SP}) : $signed({1'b0, r_y} + {1'b0, SP});
  // reaching a wall exactly also bounces, so the duck never idles a frame against it
  assign w_xlo = w_nx <= 11'sd0;
  assign w_xhi = w_nx >= $signed({1'b0, XM});
  assign w_ylo = w_ny <= 11'sd0;
  assign w_yhi = w_ny >= $signed({1'b0, GY});
  assign w_fy = {1'b0, r_y} + {1'b0, FS};
  always_ff @(posedge clk) begin
    r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    r_killed <= 1'b0;
    r_escaped <= 1'b0;
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr <= 16'hACE1;
      r_cnt <= '0;
      r_x <= '0;
      r_y <= '0;
      r_dx <= 1'b0;
      r_dy <= 1'b0;
      r_show <= 1'b0;
      r_hit <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state <= S_FLY;
          r_x <= r_lfsr[9:0] > XM ? XM : r_lfsr[9:0];
          r_y <= GY;
          r_dx <= r_lfsr[10];
          r_dy <= 1'b1;
          r_cnt <= '0;
          r_show <= 1'b1;
          r_busy <= 1'b1;
        end
        S_FLY: if (bus.shot_hit) begin
          r_state <= S_HIT;
          r_hit <= 1'b1;
          r_cnt <= '0;
        end else if (bus.new_frame) begin
          r_x <= w_xlo ? '0 : w_xhi ? XM : w_nx[9:0];
          r_y <= w_ylo ? '0 : w_yhi ? GY : w_ny[9:0];
          r_dx <= !w_xlo && (w_xhi || w_dx);
          r_dy <= !w_ylo && (w_yhi || w_dy);
          r_cnt <= r_cnt + 10'd1;
          r_state <= r_cnt + 10'd1 == FF ? S_ESC : S_FLY;
        end
        S_HIT: if (bus.new_frame) begin
          r_cnt <= r_cnt + 10'd1;
          r_state <= r_cnt + 10'd1 == HF ? S_FALL : S_HIT;
        end
        S_FALL: if (bus.new_frame) begin
          if (w_fy >= {1'b0, GY}) begin
            r_y <= GY;
            r_killed <= 1'b1;
            r_state <= S_IDLE;
            r_show <= 1'b0;
            r_hit <= 1'b0;
            r_busy <= 1'b0;
          end else begin
            r_y <= w_fy[9:0];
          end
        end
        S_ESC: if (bus.new_frame) begin
          if (r_y < SP) begin
            r_escaped <= 1'b1;
            r_state <= S_IDLE;
            r_show <= 1'b0;
            r_busy <= 1'b0;
          end else begin
            r_y <= r_y - SP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.duck_x = r_x;
  assign bus.duck_y = r_y;
  assign bus.duck_show = r_show;
  assign bus.duck_hit = r_hit;
  assign bus.killed = r_killed;
  assign bus.escaped = r_escaped;
  assign bus.busy = r_busy;
endmodule
